axis_pkt_fifo: RTL
==================

# axis_pkt_fifo

Synchronous AXI-Stream FIFO with inferred block-RAM storage, `tlast` transport, optional packet (store-and-forward) mode, occupancy counters and programmable almost-full/almost-empty flags. It is the parametrised successor of the single-clock stream FIFO and is used between DMA, MIPI/JPEG and SPI datapaths where frame boundaries must be preserved and downstream logic must see whole packets only.

## Interface
- `DEPTH`, 8192: RAM entries; power of two, ≥ 4; `AW = $clog2(DEPTH)`.
- `DW`, 24: data width.
- `PACKET_MODE`, 0: 0 = cut-through; 1 = store-and-forward on `tlast`.
- `AFULL_THRESH`, DEPTH-4: `almost_full` when `data_count ≥ AFULL_THRESH`.
- `AEMPTY_THRESH`, 4: `almost_empty` when `data_count ≤ AEMPTY_THRESH`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `s_axis_tvalid`  in  1  slave valid.
- `s_axis_tready`  out  1  slave ready.
- `s_axis_tdata`  in  DW  slave data.
- `s_axis_tlast`  in  1  slave end-of-packet.
- `m_axis_tvalid`  out  1  master valid.
- `m_axis_tready`  in  1  master ready.
- `m_axis_tdata`  out  DW  master data.
- `m_axis_tlast`  out  1  master end-of-packet.
- `data_count`  out  AW+2  words accepted but not yet delivered (RAM + output stage).
- `pkt_count`  out  AW+2  complete packets (tlast beats) accepted but not yet delivered.
- `almost_full`  out  1  threshold flag.
- `almost_empty`  out  1  threshold flag.

## Operation
- Storage: simple dual-port RAM, DEPTH × (DW+1), `{tlast, tdata}`, 1-cycle registered read. Write/read pointers are AW+1 bits; MSB disambiguates full/empty on wrap.
- Write: beat accepted on `s_axis_tvalid & s_axis_tready`. `s_axis_tready = ~ram_full`, registered.
- Output stage: 2-entry skid buffer behind the RAM read port. RAM read issued when RAM not empty, read is allowed, and skid occupancy plus in-flight read < 2. Sustains one beat/clock with `m_axis_tready` held high.
- Read allowed: `PACKET_MODE=0`: always. `PACKET_MODE=1`: `pkt_count_ram > 0` (a tlast beat is present in RAM and not yet read) or `release` is set.
- Deadlock release (packet mode): when RAM is full and `pkt_count_ram == 0`, set `release`; it stays set until a tlast beat is read from RAM, then clears. The oversize packet passes cut-through; later packets return to store-and-forward.
- `data_count`: +1 on slave handshake, −1 on master handshake, unchanged when both occur. Max value DEPTH+2.
- `pkt_count`: same rule, counting tlast beats only.
- Flags are registered and derived from the next-state `data_count`, so they are coincident with it.
- No overflow or underflow is possible; beats offered while not ready are ignored (AXIS rule).

## Timing
- Reset, asynchronous and active-low, drives `s_axis_tready=0`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `data_count=0`, `pkt_count=0`, `almost_full=0`, `almost_empty=1`, and sets pointers, skid and `release` to 0. Assertion mid-transfer discards all contents immediately.
- `s_axis_tready` rises at the first `clk` edge after `resetn` deasserts.
- Latency, cut-through: beat accepted at edge N → `m_axis_tvalid` high after edge N+2 (RAM read issued at N+1).
- Latency, packet mode: tlast accepted at edge N → first beat of that packet valid after edge N+2.
- `m_axis_tvalid`/`tdata`/`tlast` hold stable while `m_axis_tready=0`.
- Full: with DEPTH entries in RAM, `s_axis_tready` is 0 in the following cycle. A read at the full boundary re-asserts ready one cycle later. Simultaneous read and write at full/empty is legal.
- `s_axis_tready` never depends combinationally on `m_axis_tready`; there are no input-to-output combinational paths.

## Test plan
- Reset: hold `resetn=0` with random inputs → all outputs at reset values; `s_axis_tready=1` one edge after release.
- Cut-through, `DEPTH=16`, `DW=8`: stream 0x00..0x3F with `m_axis_tready=1` → output in order, first beat 2 cycles after first accept, then 1 beat/clock with no bubbles.
- Full/wrap: `m_axis_tready=0`, write 20 beats → 18 accepted (16 RAM + 2 skid), `data_count=18`, `almost_full=1`, `s_axis_tready=0`. Then drain → same values out in order, pointers wrap, `almost_empty=1` at `data_count ≤ 4`.
- Packet mode: send 5-beat packet with tlast on beat 5 → `m_axis_tvalid` stays 0 through beat 4 and rises 2 cycles after tlast accept; `pkt_count` goes 0→1→0.
- Oversize packet, packet mode, `DEPTH=16`: 40-beat packet → release fires at full and all 40 beats emerge in order. A following 3-beat packet is again held until its tlast.
- Random back-pressure on both sides, 10k beats → scoreboard matches; `data_count` equals the model every cycle; `pkt_count` is never negative.

Source files
------------

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO: BRAM storage of {tlast,tdata}, 2-entry output skid, optional
// store-and-forward on tlast with a release path for packets larger than the RAM.
module axis_pkt_fifo #(
  parameter int unsigned DEPTH         = 8192,
  parameter int unsigned DW            = 24,
  parameter bit          PACKET_MODE   = 1'b0,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DW-1:0]             s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DW-1:0]             m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [$clog2(DEPTH)+1:0]  data_count,
  output logic [$clog2(DEPTH)+1:0]  pkt_count,
  output logic                      almost_full,
  output logic                      almost_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 2;
  localparam logic [AW:0]   RAM_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AEMPTY_THRESH);

  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   rd_data_q;
  logic          rd_valid_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt, ram_cnt_d;
  logic [AW:0]   pkt_ram_q, pkt_ram_d, pkt_ram_eff;
  logic          rel_q, rel_d;
  logic          tready_q, tready_d;
  logic [DW:0]   sk0_q, sk0_d, sk1_q, sk1_d;
  logic [1:0]    sk_cnt_q, sk_cnt_d, occ;
  logic [CW-1:0] data_count_q, data_count_d, pkt_count_q, pkt_count_d;
  logic          afull_q, aempty_q;
  logic          wr_en, rd_en, m_hs, s_last_hs, rd_last, rd_allow;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (rd_en) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    wr_en     = s_axis_tvalid & tready_q;
    s_last_hs = wr_en & s_axis_tlast;
    m_hs      = (sk_cnt_q != 2'd0) & m_axis_tready;
    rd_last   = rd_valid_q & rd_data_q[DW];
    ram_cnt   = wr_ptr_q - rd_ptr_q;
    // The beat now in rd_data_q was read last cycle; discount its tlast so the
    // count reflects only tlast beats still sitting unread in RAM.
    pkt_ram_eff = pkt_ram_q - (AW+1)'(rd_last);
    rd_allow  = (PACKET_MODE == 1'b0) || (pkt_ram_eff != '0) || (rel_q && !rd_last);
    occ       = sk_cnt_q + 2'(rd_valid_q) - 2'(m_hs);
    rd_en     = (ram_cnt != '0) && rd_allow && (occ < 2'd2);

    wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_en);
    ram_cnt_d = wr_ptr_d - rd_ptr_d;
    tready_d  = (ram_cnt_d != RAM_FULL);
    pkt_ram_d = pkt_ram_q + (AW+1)'(s_last_hs) - (AW+1)'(rd_last);

    rel_d = rel_q;
    if (rd_last) rel_d = 1'b0;
    else if (PACKET_MODE && (ram_cnt == RAM_FULL) && (pkt_ram_eff == '0)) rel_d = 1'b1;

    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q;
    case ({rd_valid_q, m_hs})
      2'b10: begin
        if (sk_cnt_q == 2'd0) sk0_d = rd_data_q;
        else sk1_d = rd_data_q;
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      2'b01: begin
        sk0_d    = sk1_q;
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
      2'b11: begin
        if (sk_cnt_q == 2'd1) sk0_d = rd_data_q;
        else begin
          sk0_d = sk1_q;
          sk1_d = rd_data_q;
        end
      end
      default: ;
    endcase

    data_count_d = data_count_q + CW'(wr_en) - CW'(m_hs);
    pkt_count_d  = pkt_count_q + CW'(s_last_hs) - CW'(m_hs & sk0_q[DW]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      pkt_ram_q    <= '0;
      rel_q        <= 1'b0;
      tready_q     <= 1'b0;
      sk0_q        <= '0;
      sk1_q        <= '0;
      sk_cnt_q     <= '0;
      data_count_q <= '0;
      pkt_count_q  <= '0;
      afull_q      <= 1'b0;
      aempty_q     <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_en;
      pkt_ram_q    <= pkt_ram_d;
      rel_q        <= rel_d;
      tready_q     <= tready_d;
      sk0_q        <= sk0_d;
      sk1_q        <= sk1_d;
      sk_cnt_q     <= sk_cnt_d;
      data_count_q <= data_count_d;
      pkt_count_q  <= pkt_count_d;
      afull_q      <= (data_count_d >= AF_C);
      aempty_q     <= (data_count_d <= AE_C);
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (sk_cnt_q != 2'd0);
  assign m_axis_tdata  = sk0_q[DW-1:0];
  assign m_axis_tlast  = sk0_q[DW];
  assign data_count    = data_count_q;
  assign pkt_count     = pkt_count_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;
endmodule
